// File: rtl/cpu_pkg.sv
// cpu_pkg: shared vectors, exception FSM state encoding and branch-offset sign extension
package cpu_pkg;
  localparam logic [31:0] RST_VEC_D = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_D = 32'h0000_4180;
  typedef enum logic {NORM = 1'b0, EXC = 1'b1} exc_state_t;
  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: next-PC priority mux (jr > jmp > br_taken > pc+4); in pc/jr_tgt/jmp_idx/br_imm + selects, out pc_next
module pc_next_mux #(
  parameter int AW = 32
) (
  input  logic [AW-1:0] pc,
  input  logic          jr,
  input  logic [AW-1:0] jr_tgt,
  input  logic          jmp,
  input  logic [25:0]   jmp_idx,
  input  logic          br_taken,
  input  logic [15:0]   br_imm,
  output logic [AW-1:0] pc_next
);
  import cpu_pkg::*;
  logic [AW-1:0] pc_plus4, br_off;
  assign pc_plus4 = pc + AW'(4);
  assign br_off = AW'($signed(sext16(br_imm))) << 2;
  always_comb pc_next = jr ? jr_tgt :
                        jmp ? {pc_plus4[AW-1:28], jmp_idx, 2'b00} :
                        br_taken ? pc_plus4 + br_off : pc_plus4;
endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch PC generator with stall/ready handshake, redirects, EPC, exception FSM and update counter; out pc/pc_valid/epc/in_exc/misalign/upd_cnt
module pc_gen_unit
  import cpu_pkg::*;
#(
  parameter int            AW      = 32,
  parameter logic [AW-1:0] RST_VEC = AW'(RST_VEC_D),
  parameter logic [AW-1:0] EXC_VEC = AW'(EXC_VEC_D),
  parameter int            CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ready,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [15:0]      br_imm,
  input  logic             jmp,
  input  logic [25:0]      jmp_idx,
  input  logic             jr,
  input  logic [AW-1:0]    jr_tgt,
  input  logic             exc_req,
  input  logic             eret,
  output logic [AW-1:0]    pc,
  output logic             pc_valid,
  output logic [AW-1:0]    epc,
  output logic             in_exc,
  output logic             misalign,
  output logic [CNT_W-1:0] upd_cnt
);
  exc_state_t state, state_n;
  logic [AW-1:0] pc_mux, pc_d;
  logic adv, take_exc, take_eret, wr;
  pc_next_mux #(.AW(AW)) u_mux (
    .pc(pc), .jr(jr), .jr_tgt(jr_tgt), .jmp(jmp), .jmp_idx(jmp_idx),
    .br_taken(br_taken), .br_imm(br_imm), .pc_next(pc_mux)
  );
  assign adv = pc_valid & if_ready & ~stall;
  assign take_exc = (state == NORM) & exc_req;
  assign take_eret = (state == EXC) & eret;
  assign wr = adv | take_exc | take_eret;
  assign in_exc = state == EXC;
  assign misalign = |pc[1:0];
  always_comb begin
    state_n = take_exc ? EXC : take_eret ? NORM : state;
    pc_d = take_exc ? EXC_VEC : take_eret ? epc : adv ? pc_mux : pc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORM;
      pc <= RST_VEC;
      epc <= '0;
      upd_cnt <= '0;
      pc_valid <= 1'b0;
    end else begin
      state <= state_n;
      pc_valid <= 1'b1;
      if (wr) begin
        pc <= pc_d;
        upd_cnt <= upd_cnt + CNT_W'(1);
      end
      if (take_exc) epc <= pc;
    end
  end
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: scoreboard bench for pc_gen_unit with a spec-level reference model and random stimulus
module tb_pc_gen_unit;
  logic clk, rst, if_ready, stall, br_taken, jmp, jr, exc_req, eret;
  logic [15:0] br_imm;
  logic [25:0] jmp_idx;
  logic [31:0] jr_tgt, pc, epc, upd_cnt;
  logic pc_valid, in_exc, misalign;
  typedef struct {
    logic rst, rdy, stall, br, jmp, jr, exc, eret;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] tgt;
  } stim_t;
  typedef struct {
    logic [31:0] pc, epc, cnt;
    logic valid, exc, mis;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] m_pc, m_epc, m_cnt;
  logic m_valid, m_exc;
  pc_gen_unit dut (
    .clk(clk), .rst(rst), .if_ready(if_ready), .stall(stall), .br_taken(br_taken),
    .br_imm(br_imm), .jmp(jmp), .jmp_idx(jmp_idx), .jr(jr), .jr_tgt(jr_tgt),
    .exc_req(exc_req), .eret(eret), .pc(pc), .pc_valid(pc_valid), .epc(epc),
    .in_exc(in_exc), .misalign(misalign), .upd_cnt(upd_cnt)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.rdy = 1; s.stall = 0; s.br = 0; s.jmp = 0; s.jr = 0; s.exc = 0; s.eret = 0;
    s.imm = '0; s.idx = '0; s.tgt = '0;
    return s;
  endfunction
  function automatic stim_t jump_to(input logic [31:0] t);
    stim_t s = idle();
    s.jr = 1; s.tgt = t;
    return s;
  endfunction
  task automatic step(input stim_t s);
    exp_t e;
    int off;
    @(negedge clk);
    if_ready = s.rdy; stall = s.stall; br_taken = s.br; br_imm = s.imm; jmp = s.jmp;
    jmp_idx = s.idx; jr = s.jr; jr_tgt = s.tgt; exc_req = s.exc; eret = s.eret;
    if (s.rst) begin
      m_pc = 32'h3000; m_epc = 0; m_cnt = 0; m_valid = 0; m_exc = 0;
      if (!rst) begin
        rst = 1;
        #1;
        chk("async_rst_pc", pc, 32'h3000);
        chk("async_rst_valid", {31'b0, pc_valid}, 0);
        chk("async_rst_cnt", upd_cnt, 0);
      end
    end else begin
      rst = 0;
      if (!m_exc && s.exc) begin
        m_epc = m_pc; m_pc = 32'h4180; m_exc = 1; m_cnt++;
      end else if (m_exc && s.eret) begin
        m_pc = m_epc; m_exc = 0; m_cnt++;
      end else if (m_valid && s.rdy && !s.stall) begin
        off = $signed(s.imm);
        if (s.jr) m_pc = s.tgt;
        else if (s.jmp) m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(s.idx) * 32'd4);
        else if (s.br) m_pc = m_pc + 32'(4 + 4 * off);
        else m_pc = m_pc + 32'd4;
        m_cnt++;
      end
      m_valid = 1;
    end
    e.pc = m_pc; e.epc = m_epc; e.cnt = m_cnt; e.valid = m_valid; e.exc = m_exc; e.mis = m_pc[1:0] != 0;
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("epc", epc, e.epc);
        chk("upd_cnt", upd_cnt, e.cnt);
        chk("pc_valid", {31'b0, pc_valid}, {31'b0, e.valid});
        chk("in_exc", {31'b0, in_exc}, {31'b0, e.exc});
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
      end
    end
  end
  initial begin : driver
    stim_t s;
    rst = 0; if_ready = 0; stall = 0; br_taken = 0; br_imm = 0; jmp = 0; jmp_idx = 0;
    jr = 0; jr_tgt = 0; exc_req = 0; eret = 0;
    m_pc = 0; m_epc = 0; m_cnt = 0; m_valid = 0; m_exc = 0;
    s = idle(); s.rst = 1;
    step(s); step(s);
    repeat (5) step(idle());
    s = idle(); s.rst = 1; s.jr = 1; s.tgt = 32'h1234_5678;
    step(s);
    repeat (4) step(idle());
    s = jump_to(32'h3000); step(s);
    s = idle(); s.br = 1; s.imm = 16'hFFFF; step(s);
    s.imm = 16'h0004; step(s);
    s = jump_to(32'hABCD_0000); s.jmp = 1; s.idx = 26'h1; s.br = 1; s.imm = 16'h10; step(s);
    step(jump_to(32'h3004));
    s = idle(); s.jmp = 1; s.idx = 26'h0000C10; step(s);
    step(jump_to(32'hFFFF_FFFC));
    step(idle());
    step(jump_to(32'h3002));
    step(jump_to(32'h3100));
    for (int i = 0; i < 8; i++) begin
      s = idle(); s.br = 1; s.imm = 16'h0040;
      if (i < 4) s.stall = 1; else s.rdy = 0;
      if (i == 2) s.jr = 1;
      step(s);
    end
    s = idle(); s.br = 1; s.imm = 16'h0040; step(s);
    step(jump_to(32'h3020));
    s = idle(); s.stall = 1; s.exc = 1; step(s);
    s = idle(); s.exc = 1; step(s);
    step(idle());
    s = idle(); s.stall = 1; s.rdy = 0; s.eret = 1; step(s);
    s = idle(); s.eret = 1; step(s);
    s = idle(); s.exc = 1; s.eret = 1; s.jr = 1; s.tgt = 32'h5000; step(s);
    s = idle(); s.exc = 1; s.eret = 1; step(s);
    s = idle(); s.eret = 1; step(s);
    for (int i = 0; i < 600; i++) begin
      s = idle();
      s.rst = $urandom_range(0, 149) == 0;
      s.stall = $urandom_range(0, 3) == 0;
      s.rdy = $urandom_range(0, 4) != 0;
      s.br = $urandom_range(0, 2) == 0;
      s.imm = 16'($urandom);
      s.jmp = $urandom_range(0, 5) == 0;
      s.idx = 26'($urandom);
      s.jr = $urandom_range(0, 7) == 0;
      s.tgt = $urandom;
      if ($urandom_range(0, 3) != 0) s.tgt[1:0] = 2'b00;
      s.exc = $urandom_range(0, 19) == 0;
      s.eret = $urandom_range(0, 14) == 0;
      step(s);
    end
    step(idle());
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
